// File: rtl/bp_resolve_queue.sv
// Branch resolution back end: registered frontend redirect, predictor training FIFO
// and a saturating mispredict counter.
module bp_resolve_queue #(
  parameter int PCLEN = 128,
  parameter int VLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             resolve_valid_i,
  input  logic [VLEN-1:0]  resolve_pc_i,
  input  logic [PCLEN-1:0] resolve_target_i,
  input  logic             resolve_taken_i,
  input  logic             resolve_mispredict_i,
  input  logic [2:0]       resolve_cf_i,
  input  logic             resolve_exc_i,
  output logic             redirect_valid_o,
  output logic [PCLEN-1:0] redirect_pcc_o,
  input  logic             redirect_ready_i,
  output logic             busy_o,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [VLEN-1:0]  upd_pc_o,
  output logic [VLEN-1:0]  upd_target_o,
  output logic [2:0]       upd_cf_o,
  output logic             upd_taken_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic [CNTW-1:0]  mispredict_cnt_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  localparam logic [2:0] CF_NOCF   = 3'd0;
  localparam logic [2:0] CF_BRANCH = 3'd1;
  localparam logic [2:0] CF_JUMP   = 3'd2;
  localparam logic [2:0] CF_JUMPR  = 3'd3;
  localparam logic [2:0] CF_RETURN = 3'd4;

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_e;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
    logic [2:0]      cf;
    logic            taken;
  } upd_t;

  logic acc;
  logic mp_acc;

  assign acc    = resolve_valid_i & ~resolve_exc_i;
  assign mp_acc = acc & resolve_mispredict_i;

  state_e           state_q, state_d;
  logic [PCLEN-1:0] pcc_q, pcc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pcc_q   <= '0;
    end else begin
      state_q <= state_d;
      pcc_q   <= pcc_d;
    end
  end

  // Flush beats everything; a fresh mispredict always wins over a pending handshake.
  always_comb begin
    state_d = state_q;
    pcc_d   = pcc_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (mp_acc) begin
      state_d = REDIRECT;
      pcc_d   = resolve_target_i;
    end else if (state_q == REDIRECT && redirect_ready_i) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    redirect_valid_o = (state_q == REDIRECT);
    busy_o           = (state_q == REDIRECT);
    redirect_pcc_o   = pcc_q;
  end

  upd_t            mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            fifo_full;
  upd_t            push_entry;
  upd_t            head;

  assign fifo_full = (count_q == CW'(DEPTH));
  assign pop       = (count_q != '0) & upd_ready_i;

  // Returns are left to the RAS and NoCF carries nothing worth learning.
  assign push_req = acc & ((resolve_cf_i == CF_BRANCH) |
                           (resolve_mispredict_i & (resolve_cf_i != CF_NOCF) &
                            (resolve_cf_i != CF_RETURN)));
  assign push_ok  = push_req & (~fifo_full | pop);

  always_comb begin
    push_entry.pc     = resolve_pc_i;
    push_entry.target = resolve_target_i[VLEN-1:0];
    push_entry.cf     = (resolve_cf_i == CF_JUMP && resolve_mispredict_i) ? CF_JUMPR
                                                                          : resolve_cf_i;
    push_entry.taken  = resolve_taken_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    upd_valid_o  = (count_q != '0);
    upd_pc_o     = upd_valid_o ? head.pc     : '0;
    upd_target_o = upd_valid_o ? head.target : '0;
    upd_cf_o     = upd_valid_o ? head.cf     : '0;
    upd_taken_o  = upd_valid_o ? head.taken  : 1'b0;
    full_o       = fifo_full;
    overflow_o   = ovf_q;
  end

  logic [CNTW-1:0] cnt_q, cnt_d;

  // Counting ignores flush so the CSR reflects every real mispredict.
  always_comb begin
    cnt_d = cnt_q;
    if (mp_acc && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: vector table plus hand-written corner sequences.
module tb_bp_resolve_queue;

  localparam logic [2:0] NOCF   = 3'd0;
  localparam logic [2:0] BRANCH = 3'd1;
  localparam logic [2:0] JUMP   = 3'd2;
  localparam logic [2:0] JUMPR  = 3'd3;
  localparam logic [2:0] RET    = 3'd4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         resValid;
  logic [63:0]  resPc;
  logic [127:0] resTarget;
  logic         resTaken;
  logic         resMisp;
  logic [2:0]   resCf;
  logic         resExc;
  logic         redirValid;
  logic [127:0] redirPcc;
  logic         redirReady;
  logic         busy;
  logic         updValid;
  logic         updReady;
  logic [63:0]  updPc;
  logic [63:0]  updTarget;
  logic [2:0]   updCf;
  logic         updTaken;
  logic         full;
  logic         overflow;
  logic [31:0]  mispCnt;

  logic         sRedirValid;
  logic [127:0] sRedirPcc;
  logic         sBusy;
  logic         sUpdValid;
  logic [63:0]  sUpdPc;
  logic [63:0]  sUpdTarget;
  logic [2:0]   sUpdCf;
  logic         sUpdTaken;
  logic         sFull;
  logic         sOverflow;
  logic [1:0]   sCnt;

  int tests = 0;
  int fails = 0;

  bp_resolve_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .resolve_valid_i(resValid), .resolve_pc_i(resPc), .resolve_target_i(resTarget),
    .resolve_taken_i(resTaken), .resolve_mispredict_i(resMisp), .resolve_cf_i(resCf),
    .resolve_exc_i(resExc),
    .redirect_valid_o(redirValid), .redirect_pcc_o(redirPcc), .redirect_ready_i(redirReady),
    .busy_o(busy),
    .upd_valid_o(updValid), .upd_ready_i(updReady), .upd_pc_o(updPc),
    .upd_target_o(updTarget), .upd_cf_o(updCf), .upd_taken_o(updTaken),
    .full_o(full), .overflow_o(overflow), .mispredict_cnt_o(mispCnt)
  );

  // Narrow-counter copy driven by the same stimulus, used to reach saturation.
  bp_resolve_queue #(.CNTW(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .resolve_valid_i(resValid), .resolve_pc_i(resPc), .resolve_target_i(resTarget),
    .resolve_taken_i(resTaken), .resolve_mispredict_i(resMisp), .resolve_cf_i(resCf),
    .resolve_exc_i(resExc),
    .redirect_valid_o(sRedirValid), .redirect_pcc_o(sRedirPcc), .redirect_ready_i(redirReady),
    .busy_o(sBusy),
    .upd_valid_o(sUpdValid), .upd_ready_i(updReady), .upd_pc_o(sUpdPc),
    .upd_target_o(sUpdTarget), .upd_cf_o(sUpdCf), .upd_taken_o(sUpdTaken),
    .full_o(sFull), .overflow_o(sOverflow), .mispredict_cnt_o(sCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush;
    logic        rv;
    logic [2:0]  cf;
    logic [63:0] pc;
    logic [63:0] tAddr;
    logic        tk;
    logic        mp;
    logic        exc;
    logic        rrdy;
    logic        urdy;
  } stim_t;

  typedef struct {
    logic        rv;
    logic [63:0] pccAddr;
    logic        uv;
    logic [63:0] upc;
    logic [63:0] utgt;
    logic [2:0]  ucf;
    logic        utk;
    logic        full;
    logic        ovf;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  function automatic logic [127:0] tgtOf(input logic [63:0] addr);
    return {~addr, addr};
  endfunction

  function automatic stim_t mkStim(input logic fl, input logic rv, input logic [2:0] cf,
                                   input logic [63:0] pc, input logic [63:0] ta,
                                   input logic tk, input logic mp, input logic exc,
                                   input logic rrdy, input logic urdy);
    stim_t s;
    s.flush = fl; s.rv = rv; s.cf = cf; s.pc = pc; s.tAddr = ta;
    s.tk = tk; s.mp = mp; s.exc = exc; s.rrdy = rrdy; s.urdy = urdy;
    return s;
  endfunction

  function automatic stim_t idle(input logic rrdy, input logic urdy);
    return mkStim(1'b0, 1'b0, NOCF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, rrdy, urdy);
  endfunction

  function automatic exp_t mkExp(input logic rv, input logic [63:0] pa, input logic uv,
                                 input logic [63:0] upc, input logic [63:0] utgt,
                                 input logic [2:0] ucf, input logic utk, input logic fu,
                                 input logic ovf, input logic [31:0] cnt);
    exp_t e;
    e.rv = rv; e.pccAddr = pa; e.uv = uv; e.upc = upc; e.utgt = utgt;
    e.ucf = ucf; e.utk = utk; e.full = fu; e.ovf = ovf; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t noUpd(input logic rv, input logic [63:0] pa, input logic ovf,
                                 input logic [31:0] cnt);
    return mkExp(rv, pa, 1'b0, 64'h0, 64'h0, NOCF, 1'b0, 1'b0, ovf, cnt);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input stim_t s);
    flush      = s.flush;
    resValid   = s.rv;
    resCf      = s.cf;
    resPc      = s.pc;
    resTarget  = tgtOf(s.tAddr);
    resTaken   = s.tk;
    resMisp    = s.mp;
    resExc     = s.exc;
    redirReady = s.rrdy;
    updReady   = s.urdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    logic [31:0] satExp;
    satExp = (e.cnt > 32'd3) ? 32'd3 : e.cnt;
    chk({tag, ".redirect_valid"}, 128'(redirValid), 128'(e.rv));
    chk({tag, ".busy"}, 128'(busy), 128'(e.rv));
    if (e.rv) chk({tag, ".redirect_pcc"}, redirPcc, tgtOf(e.pccAddr));
    chk({tag, ".upd_valid"}, 128'(updValid), 128'(e.uv));
    if (e.uv) begin
      chk({tag, ".upd_pc"}, 128'(updPc), 128'(e.upc));
      chk({tag, ".upd_target"}, 128'(updTarget), 128'(e.utgt));
      chk({tag, ".upd_cf"}, 128'(updCf), 128'(e.ucf));
      chk({tag, ".upd_taken"}, 128'(updTaken), 128'(e.utk));
    end
    chk({tag, ".full"}, 128'(full), 128'(e.full));
    chk({tag, ".overflow"}, 128'(overflow), 128'(e.ovf));
    chk({tag, ".mispredict_cnt"}, 128'(mispCnt), 128'(e.cnt));
    chk({tag, ".sat_cnt"}, 128'(sCnt), 128'(satExp));
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, ".redirect_valid"}, 128'(redirValid), 128'(0));
    chk({tag, ".redirect_pcc"}, redirPcc, 128'(0));
    chk({tag, ".busy"}, 128'(busy), 128'(0));
    chk({tag, ".upd_valid"}, 128'(updValid), 128'(0));
    chk({tag, ".upd_pc"}, 128'(updPc), 128'(0));
    chk({tag, ".upd_target"}, 128'(updTarget), 128'(0));
    chk({tag, ".upd_cf"}, 128'(updCf), 128'(0));
    chk({tag, ".upd_taken"}, 128'(updTaken), 128'(0));
    chk({tag, ".full"}, 128'(full), 128'(0));
    chk({tag, ".overflow"}, 128'(overflow), 128'(0));
    chk({tag, ".mispredict_cnt"}, 128'(mispCnt), 128'(0));
    chk({tag, ".sat_cnt"}, 128'(sCnt), 128'(0));
  endtask

  function automatic logic [63:0] ovPc(input int i);
    return 64'h9000_0000 + 64'(i * 16);
  endfunction

  function automatic logic [63:0] ovTgt(input int i);
    return 64'h9100_0000 + 64'(i * 16);
  endfunction

  vec_t vecs[11];

  initial begin
    vecs[0].s  = idle(1'b0, 1'b0);
    vecs[0].e  = noUpd(1'b0, 64'h0, 1'b0, 32'd0);
    vecs[1].s  = mkStim(0, 1, JUMP, 64'h8000_0010, 64'h8000_0100, 1, 1, 0, 1, 0);
    vecs[1].e  = mkExp(1, 64'h8000_0100, 1, 64'h8000_0010, 64'h8000_0100, JUMPR, 1, 0, 0, 1);
    vecs[2].s  = idle(1'b1, 1'b1);
    vecs[2].e  = noUpd(1'b0, 64'h0, 1'b0, 32'd1);
    vecs[3].s  = mkStim(0, 1, BRANCH, 64'h8000_0020, 64'h8000_0200, 1, 0, 0, 0, 0);
    vecs[3].e  = mkExp(0, 64'h0, 1, 64'h8000_0020, 64'h8000_0200, BRANCH, 1, 0, 0, 1);
    vecs[4].s  = mkStim(0, 1, NOCF, 64'h8000_0030, 64'h8000_0300, 0, 1, 0, 0, 0);
    vecs[4].e  = mkExp(1, 64'h8000_0300, 1, 64'h8000_0020, 64'h8000_0200, BRANCH, 1, 0, 0, 2);
    vecs[5].s  = mkStim(0, 1, RET, 64'h8000_0040, 64'h8000_0400, 1, 1, 0, 0, 0);
    vecs[5].e  = mkExp(1, 64'h8000_0400, 1, 64'h8000_0020, 64'h8000_0200, BRANCH, 1, 0, 0, 3);
    vecs[6].s  = mkStim(0, 1, BRANCH, 64'h8000_0050, 64'h8000_0500, 1, 1, 1, 0, 0);
    vecs[6].e  = mkExp(1, 64'h8000_0400, 1, 64'h8000_0020, 64'h8000_0200, BRANCH, 1, 0, 0, 3);
    vecs[7].s  = mkStim(0, 1, BRANCH, 64'h8000_0060, 64'h8000_0600, 0, 1, 0, 1, 0);
    vecs[7].e  = mkExp(1, 64'h8000_0600, 1, 64'h8000_0020, 64'h8000_0200, BRANCH, 1, 0, 0, 4);
    vecs[8].s  = mkStim(1, 1, JUMPR, 64'h8000_0070, 64'h8000_0700, 1, 1, 0, 0, 1);
    vecs[8].e  = mkExp(0, 64'h0, 1, 64'h8000_0060, 64'h8000_0600, BRANCH, 0, 0, 0, 5);
    vecs[9].s  = idle(1'b0, 1'b1);
    vecs[9].e  = mkExp(0, 64'h0, 1, 64'h8000_0070, 64'h8000_0700, JUMPR, 1, 0, 0, 5);
    vecs[10].s = idle(1'b0, 1'b1);
    vecs[10].e = noUpd(1'b0, 64'h0, 1'b0, 32'd5);

    rst = 1'b1;
    applyStimulus(mkStim(0, 1, JUMP, 64'h1, 64'h2, 1, 1, 0, 0, 0));
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Fill with the predictor stalled; the fifth update must be dropped.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkStim(0, 1, BRANCH, ovPc(i), ovTgt(i), i[0], 0, 0, 0, 0));
      checkOutput($sformatf("fill%0d", i),
                  mkExp(0, 64'h0, 1, ovPc(0), ovTgt(0), BRANCH, 1'b0, (i >= 3), (i == 4), 5));
    end

    applyStimulus(mkStim(0, 1, BRANCH, ovPc(5), ovTgt(5), 1, 0, 0, 0, 1));
    checkOutput("fullPushPop", mkExp(0, 64'h0, 1, ovPc(1), ovTgt(1), BRANCH, 1'b1, 1, 1, 5));

    begin
      int order[3] = '{2, 3, 5};
      for (int j = 0; j < 3; j++) begin
        applyStimulus(idle(1'b0, 1'b1));
        checkOutput($sformatf("drain%0d", j),
                    mkExp(0, 64'h0, 1, ovPc(order[j]), ovTgt(order[j]), BRANCH,
                          order[j][0], 0, 1, 5));
      end
    end
    applyStimulus(idle(1'b0, 1'b1));
    checkOutput("drainEmpty", noUpd(1'b0, 64'h0, 1'b1, 32'd5));

    applyStimulus(mkStim(1, 1, NOCF, 64'hB000_0000, 64'hB100_0000, 1, 1, 0, 0, 1));
    checkOutput("flushMisp", noUpd(1'b0, 64'h0, 1'b1, 32'd6));

    applyStimulus(mkStim(0, 1, NOCF, 64'hB000_0010, 64'hB100_0010, 1, 1, 0, 0, 1));
    checkOutput("pendRedirect", noUpd(1'b1, 64'hB100_0010, 1'b1, 32'd7));
    applyStimulus(mkStim(1, 0, NOCF, 64'h0, 64'h0, 0, 0, 0, 0, 1));
    checkOutput("flushPending", noUpd(1'b0, 64'h0, 1'b1, 32'd7));

    applyStimulus(mkStim(0, 1, BRANCH, 64'hC000_0000, 64'hC100_0000, 1, 0, 0, 0, 0));
    checkOutput("preRst0", mkExp(0, 64'h0, 1, 64'hC000_0000, 64'hC100_0000, BRANCH, 1, 0, 1, 7));
    applyStimulus(mkStim(0, 1, BRANCH, 64'hC000_0010, 64'hC100_0010, 0, 1, 0, 0, 0));
    checkOutput("preRst1",
                mkExp(1, 64'hC100_0010, 1, 64'hC000_0000, 64'hC100_0000, BRANCH, 1, 0, 1, 8));
    applyStimulus(idle(1'b0, 1'b1));
    checkOutput("preRst2",
                mkExp(1, 64'hC100_0010, 1, 64'hC000_0010, 64'hC100_0010, BRANCH, 0, 0, 1, 8));

    rst = 1'b1;
    applyStimulus(mkStim(0, 1, JUMP, 64'hD000_0000, 64'hD100_0000, 1, 1, 0, 0, 1));
    checkAllZero("midDrainReset");
    rst = 1'b0;
    applyStimulus(idle(1'b0, 1'b0));
    checkAllZero("postReset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
